// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: hazard inputs from the pipeline and the stall/flush controls returned to it.
interface hazard_stall_controller_if #(parameter int CNT_W = 32);
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic             hilo_use_id;
    logic             r_enable_ex;
    logic [4:0]       reg_dest_ex;
    logic             muldiv_start_ex;
    logic             pcsel_mem;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             muldiv_busy;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output rs_id, rt_id, uses_rs_id, uses_rt_id, hilo_use_id,
               r_enable_ex, reg_dest_ex, muldiv_start_ex, pcsel_mem,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
               id_ex_flush, ex_mem_flush, muldiv_busy, stall_cycles
    );
    modport slave (
        input  rs_id, rt_id, uses_rs_id, uses_rt_id, hilo_use_id,
               r_enable_ex, reg_dest_ex, muldiv_start_ex, pcsel_mem,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
               id_ex_flush, ex_mem_flush, muldiv_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use / HI-LO stall and branch flush sequencer for a 5-stage MIPS pipeline.
module hazard_stall_controller #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 32
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    hazard_stall_controller_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int LAT_W = MULDIV_LAT > 1 ? $clog2(MULDIV_LAT) : 1;
    state_t           state_q;
    logic [LAT_W-1:0] count_q;
    logic             busy_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             load_use;
    logic             md_start;
    logic             hilo_stall;
    logic             stall;
    logic             flush;
    assign load_use   = bus.r_enable_ex && bus.reg_dest_ex != 5'd0 &&
                        ((bus.uses_rs_id && bus.rs_id == bus.reg_dest_ex) ||
                         (bus.uses_rt_id && bus.rt_id == bus.reg_dest_ex));
    // A start paired with a taken branch belongs to a squashed instruction.
    assign md_start   = bus.muldiv_start_ex && !bus.pcsel_mem;
    assign hilo_stall = bus.hilo_use_id && (md_start || state_q == BUSY);
    assign stall      = load_use || hilo_stall;
    assign flush      = bus.pcsel_mem;
    always_comb begin
        stall_cnt_d = (stall && !flush && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
    assign bus.pc_write     = rst_ni && (flush || !stall);
    assign bus.if_id_write  = rst_ni && (flush || !stall);
    assign bus.id_ex_bubble = rst_ni && !flush && stall;
    assign bus.if_id_flush  = rst_ni && flush;
    assign bus.id_ex_flush  = rst_ni && flush;
    assign bus.ex_mem_flush = rst_ni && flush;
    assign bus.muldiv_busy  = busy_q;
    assign bus.stall_cycles = stall_cnt_q;
    // A branch during BUSY never aborts: the op in flight is older than the branch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (state_q == IDLE) begin
                if (md_start && MULDIV_LAT > 1) begin
                    state_q <= BUSY;
                    busy_q  <= 1'b1;
                    count_q <= LAT_W'(MULDIV_LAT - 1);
                end
            end else if (count_q == LAT_W'(1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                count_q <= '0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: vector table, corner sequences and randomized run against a cycle-count model.
module tb_hazard_stall_controller;
    localparam int LAT_A = 4;
    localparam int CW_A  = 4;
    localparam int LAT_B = 1;
    localparam int CW_B  = 8;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       hilo;
        logic       ren;
        logic [4:0] rd;
        logic       mds;
        logic       pcsel;
    } stim_t;
    typedef struct packed {
        stim_t      s;
        logic [3:0] ctl;
    } vec_t;
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    stim_t  s = '0;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint bu_a = -1;
    longint bu_b = -1;
    longint cnt_a = 0;
    longint cnt_b = 0;
    hazard_stall_controller_if #(.CNT_W(CW_A)) ifa();
    hazard_stall_controller_if #(.CNT_W(CW_B)) ifb();
    assign ifa.rs_id = s.rs;             assign ifb.rs_id = s.rs;
    assign ifa.rt_id = s.rt;             assign ifb.rt_id = s.rt;
    assign ifa.uses_rs_id = s.urs;       assign ifb.uses_rs_id = s.urs;
    assign ifa.uses_rt_id = s.urt;       assign ifb.uses_rt_id = s.urt;
    assign ifa.hilo_use_id = s.hilo;     assign ifb.hilo_use_id = s.hilo;
    assign ifa.r_enable_ex = s.ren;      assign ifb.r_enable_ex = s.ren;
    assign ifa.reg_dest_ex = s.rd;       assign ifb.reg_dest_ex = s.rd;
    assign ifa.muldiv_start_ex = s.mds;  assign ifb.muldiv_start_ex = s.mds;
    assign ifa.pcsel_mem = s.pcsel;      assign ifb.pcsel_mem = s.pcsel;
    hazard_stall_controller #(.MULDIV_LAT(LAT_A), .CNT_W(CW_A)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    hazard_stall_controller #(.MULDIV_LAT(LAT_B), .CNT_W(CW_B)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));
    always #5 clk = ~clk;
    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // {PCWrite, IF_ID_Write, ID_EX_Bubble, flush}
    function automatic logic [3:0] ctl(logic pcsel, logic stall_cond);
        return pcsel ? 4'b1101 : stall_cond ? 4'b0010 : 4'b1100;
    endfunction
    task automatic model_cycle();
        logic lu, mds, ba, bb, sa, sb;
        logic [3:0] ea, eb;
        lu  = s.ren && s.rd != 0 && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
        mds = s.mds && !s.pcsel;
        ba  = cyc <= bu_a;
        bb  = cyc <= bu_b;
        sa  = lu || (s.hilo && (mds || ba));
        sb  = lu || (s.hilo && (mds || bb));
        ea  = ctl(s.pcsel, sa);
        eb  = ctl(s.pcsel, sb);
        chk("a_pc_write", ifa.pc_write, ea[3]);
        chk("a_if_id_write", ifa.if_id_write, ea[2]);
        chk("a_bubble", ifa.id_ex_bubble, ea[1]);
        chk("a_if_id_flush", ifa.if_id_flush, ea[0]);
        chk("a_id_ex_flush", ifa.id_ex_flush, ea[0]);
        chk("a_ex_mem_flush", ifa.ex_mem_flush, ea[0]);
        chk("a_busy", ifa.muldiv_busy, ba);
        chk("a_stall_cycles", ifa.stall_cycles, cnt_a);
        chk("b_pc_write", ifb.pc_write, eb[3]);
        chk("b_bubble", ifb.id_ex_bubble, eb[1]);
        chk("b_ex_mem_flush", ifb.ex_mem_flush, eb[0]);
        chk("b_busy", ifb.muldiv_busy, bb);
        chk("b_stall_cycles", ifb.stall_cycles, cnt_b);
        if (sa && !s.pcsel && cnt_a < (1 << CW_A) - 1) cnt_a++;
        if (sb && !s.pcsel && cnt_b < (1 << CW_B) - 1) cnt_b++;
        if (mds && !ba && LAT_A > 1) bu_a = cyc + LAT_A - 1;
        if (mds && !bb && LAT_B > 1) bu_b = cyc + LAT_B - 1;
        cyc++;
    endtask
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        s = '0;
        #2;
        chk("rst_pc_write", ifa.pc_write, 0);
        chk("rst_if_id_write", ifa.if_id_write, 0);
        chk("rst_bubble", ifa.id_ex_bubble, 0);
        chk("rst_flushes", {ifa.if_id_flush, ifa.id_ex_flush, ifa.ex_mem_flush}, 0);
        chk("rst_busy", ifa.muldiv_busy, 0);
        chk("rst_stall_cycles", ifa.stall_cycles, 0);
        bu_a = -1; bu_b = -1; cnt_a = 0; cnt_b = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    vec_t vecs[10];
    initial begin
        // rs, rt, urs, urt, hilo, ren, rd, mds, pcsel
        vecs[0] = '{s: '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 0}, ctl: 4'b0010};
        vecs[1] = '{s: '{5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0}, ctl: 4'b1100};
        vecs[2] = '{s: '{5'd8, 5'd8, 0, 0, 0, 1, 5'd8, 0, 0}, ctl: 4'b1100};
        vecs[3] = '{s: '{5'd3, 5'd8, 1, 1, 0, 1, 5'd8, 0, 0}, ctl: 4'b0010};
        vecs[4] = '{s: '{5'd8, 5'd8, 1, 1, 0, 0, 5'd8, 0, 0}, ctl: 4'b1100};
        vecs[5] = '{s: '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 1}, ctl: 4'b1101};
        vecs[6] = '{s: '{5'd1, 5'd2, 1, 1, 0, 1, 5'd9, 0, 0}, ctl: 4'b1100};
        vecs[7] = '{s: '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0}, ctl: 4'b1100};
        vecs[8] = '{s: '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 1}, ctl: 4'b1101};
        vecs[9] = '{s: '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0}, ctl: 4'b0010};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s = vecs[i].s;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i),
                {ifa.pc_write, ifa.if_id_write, ifa.id_ex_bubble, ifa.ex_mem_flush}, vecs[i].ctl);
            if (i == 1) chk("vec0_stall_cycles", ifa.stall_cycles, 1);
            if (i == 6) chk("vec5_no_count", ifa.stall_cycles, 2);
            if (i == 9) chk("flushed_start_idle", ifa.muldiv_busy, 0);
            model_cycle();
            @(posedge clk);
            #1;
        end
        // mult in EX, mflo held in ID behind it
        do_reset();
        s = '0; s.mds = 1'b1;
        step();
        s = '0; s.hilo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mflo_busy", ifa.muldiv_busy, 1);
            chk("mflo_stalled", ifa.pc_write, 0);
            model_cycle();
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mflo_released", ifa.pc_write, 1);
        chk("mflo_stall_cycles", ifa.stall_cycles, 3);
        model_cycle();
        @(posedge clk);
        #1;
        // asynchronous reset while the unit is busy
        s = '0; s.mds = 1'b1;
        step();
        s = '0;
        step();
        chk("busy_before_reset", ifa.muldiv_busy, 1);
        do_reset();
        step();
        chk("idle_after_reset", ifa.muldiv_busy, 0);
        // saturation of the 4-bit counter under a held load-use
        s = '0; s.ren = 1'b1; s.rd = 5'd8; s.urs = 1'b1; s.rs = 5'd8;
        for (int i = 0; i < 20; i++) step();
        chk("saturated_15", ifa.stall_cycles, 15);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s.rs    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(7 + $urandom_range(0, 2));
            s.rt    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(7 + $urandom_range(0, 2));
            s.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(7 + $urandom_range(0, 2));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.ren   = ($urandom_range(0, 2) == 0);
            s.hilo  = ($urandom_range(0, 2) == 0);
            s.pcsel = ($urandom_range(0, 7) == 0);
            s.mds   = ($urandom_range(0, 6) == 0) && !(cyc <= bu_a);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
